// File: rtl/wind_pkg.sv
// Shared types and constants for the wind measurement scheduler.
package wind_pkg;

  localparam int unsigned SAMPLE_W = 12;
  localparam int unsigned SPEED_W  = 16;

  localparam logic signed [SPEED_W-1:0] SENTINEL = 16'sh8000;

  localparam logic AXIS_X = 1'b0;
  localparam logic AXIS_Y = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR_X  = 3'd1,
    ST_ACQ_X  = 3'd2,
    ST_WAIT_X = 3'd3,
    ST_CLR_Y  = 3'd4,
    ST_ACQ_Y  = 3'd5,
    ST_WAIT_Y = 3'd6,
    ST_DONE   = 3'd7
  } state_e;

  // Axis served by a given state (IDLE/DONE report X, which is harmless).
  function automatic logic state_axis(input state_e s);
    return (s == ST_CLR_Y || s == ST_ACQ_Y || s == ST_WAIT_Y) ? AXIS_Y : AXIS_X;
  endfunction

endpackage

// File: rtl/wind_strobe_gen.sv
// Free-running sample divider: stb_o is high for one cycle when the count is SAMPLE_DIV-1.
module wind_strobe_gen #(
  parameter int unsigned SAMPLE_DIV = 100
) (
  input  logic clock,
  input  logic reset,
  output logic stb_o
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stb_q, stb_d;

  // Wrap the count and pre-compute the strobe so it lines up with the last count.
  always_comb begin
    cnt_d = (cnt_q == CNT_W'(SAMPLE_DIV - 1)) ? '0 : cnt_q + CNT_W'(1);
    stb_d = (cnt_d == CNT_W'(SAMPLE_DIV - 1));
  end

  // Divider registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      stb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      stb_q <= stb_d;
    end
  end

  assign stb_o = stb_q;

endmodule

// File: rtl/wind_meas_sched.sv
// Sequences one X+Y wind measurement over a shared datapath and publishes both speeds.
module wind_meas_sched
  import wind_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 100,
  parameter int unsigned WINDOW     = 2000,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned TIMEOUT    = 4096,
  parameter int unsigned CLR_CYC    = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                continuous,
  input  logic                abort,
  input  logic [SAMPLE_W-1:0] rx1,
  input  logic [SAMPLE_W-1:0] rx2,
  input  logic [SAMPLE_W-1:0] rx3,
  input  logic [SAMPLE_W-1:0] rx4,
  output logic [SAMPLE_W-1:0] dp_rx1,
  output logic [SAMPLE_W-1:0] dp_rx2,
  output logic                dp_endata,
  output logic                dp_reset,
  input  logic [SPEED_W-1:0]  dp_speed,
  input  logic                dp_valid,
  output logic                tx_x,
  output logic                tx_y,
  output logic [SPEED_W-1:0]  speed_x,
  output logic [SPEED_W-1:0]  speed_y,
  output logic                meas_valid,
  output logic [1:0]          err,
  output logic                busy
);

  localparam int unsigned WIN_W = $clog2(WINDOW + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned CLR_W = $clog2(CLR_CYC + 2);

  state_e state_q, state_d;

  logic [CLR_W-1:0]    clr_cnt_q, clr_cnt_d;
  logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
  logic [TO_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic                got_q, got_d;
  logic [SPEED_W-1:0]  shadow_x_q, shadow_x_d;
  logic [SPEED_W-1:0]  shadow_y_q, shadow_y_d;
  logic [1:0]          errp_q, errp_d;

  logic [SAMPLE_W-1:0] dp_rx1_q, dp_rx1_d;
  logic [SAMPLE_W-1:0] dp_rx2_q, dp_rx2_d;
  logic                dp_endata_q, dp_endata_d;
  logic                dp_reset_q, dp_reset_d;
  logic                tx_x_q, tx_x_d;
  logic                tx_y_q, tx_y_d;
  logic [SPEED_W-1:0]  speed_x_q, speed_x_d;
  logic [SPEED_W-1:0]  speed_y_q, speed_y_d;
  logic                meas_valid_q, meas_valid_d;
  logic [1:0]          err_q, err_d;
  logic                busy_q, busy_d;

  logic stb;
  logic in_clr, in_acq, in_wait, in_cap;
  logic clr_done, win_full, wait_last, wait_exit;
  logic axis;

  wind_strobe_gen #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_stb (
    .clock(clock),
    .reset(reset),
    .stb_o(stb)
  );

  assign in_clr    = (state_q == ST_CLR_X)  || (state_q == ST_CLR_Y);
  assign in_acq    = (state_q == ST_ACQ_X)  || (state_q == ST_ACQ_Y);
  assign in_wait   = (state_q == ST_WAIT_X) || (state_q == ST_WAIT_Y);
  assign in_cap    = in_acq || in_wait;
  assign axis      = state_axis(state_q);
  assign clr_done  = (clr_cnt_q >= CLR_W'(CLR_CYC));
  assign win_full  = (win_cnt_q == WIN_W'(WINDOW));
  assign wait_last = (wait_cnt_q == TO_W'(TIMEOUT - 1));
  assign wait_exit = got_q || dp_valid || wait_last;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_CLR_X;
      ST_CLR_X:  if (clr_done && stb) state_d = ST_ACQ_X;
      ST_ACQ_X:  if (win_full) state_d = ST_WAIT_X;
      ST_WAIT_X: if (wait_exit) state_d = ST_CLR_Y;
      ST_CLR_Y:  if (clr_done && stb) state_d = ST_ACQ_Y;
      ST_ACQ_Y:  if (win_full) state_d = ST_WAIT_Y;
      ST_WAIT_Y: if (wait_exit) state_d = ST_DONE;
      ST_DONE:   state_d = continuous ? ST_CLR_X : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // Counters, capture shadows and registered outputs derived from the next state.
  always_comb begin
    logic sample;
    logic tx_win;
    logic enter;

    clr_cnt_d    = clr_cnt_q;
    win_cnt_d    = win_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    got_d        = got_q;
    shadow_x_d   = shadow_x_q;
    shadow_y_d   = shadow_y_q;
    errp_d       = errp_q;
    dp_rx1_d     = dp_rx1_q;
    dp_rx2_d     = dp_rx2_q;
    speed_x_d    = speed_x_q;
    speed_y_d    = speed_y_q;
    err_d        = err_q;

    enter  = (state_d != state_q);
    sample = in_acq && stb && !win_full && !abort;

    // Clear-phase cycle counter, restarted on every CLR entry.
    if (enter && (state_d == ST_CLR_X || state_d == ST_CLR_Y)) begin
      clr_cnt_d = '0;
    end else if (in_clr && !clr_done) begin
      clr_cnt_d = clr_cnt_q + CLR_W'(1);
    end

    // Window strobe counter, saturating at WINDOW.
    if (enter && (state_d == ST_ACQ_X || state_d == ST_ACQ_Y)) begin
      win_cnt_d = '0;
    end else if (sample) begin
      win_cnt_d = win_cnt_q + WIN_W'(1);
    end

    // Cycles spent waiting for the datapath result.
    if (enter && (state_d == ST_WAIT_X || state_d == ST_WAIT_Y)) begin
      wait_cnt_d = '0;
    end else if (in_wait && !wait_last) begin
      wait_cnt_d = wait_cnt_q + TO_W'(1);
    end

    // Route the active axis pair into the datapath on each strobe.
    if (sample) begin
      dp_rx1_d = (axis == AXIS_X) ? rx2 : rx1;
      dp_rx2_d = (axis == AXIS_X) ? rx4 : rx3;
    end

    // Error bits describe the measurement in progress only.
    if (enter && state_d == ST_CLR_X) errp_d = '0;

    if (in_clr) got_d = 1'b0;

    // Capture the latest datapath result; on timeout substitute the sentinel.
    if (in_cap && dp_valid) begin
      got_d = 1'b1;
      if (axis == AXIS_X) shadow_x_d = dp_speed;
      else                shadow_y_d = dp_speed;
    end else if (in_wait && !got_q && wait_last && !abort) begin
      if (axis == AXIS_X) begin
        shadow_x_d = SENTINEL;
        errp_d[0]  = 1'b1;
      end else begin
        shadow_y_d = SENTINEL;
        errp_d[1]  = 1'b1;
      end
    end

    tx_win = (32'(win_cnt_d) < BURST_LEN) || (BURST_LEN >= WINDOW);

    busy_d       = (state_d != ST_IDLE);
    dp_reset_d   = (state_d == ST_CLR_X || state_d == ST_CLR_Y) &&
                   (clr_cnt_d < CLR_W'(CLR_CYC));
    dp_endata_d  = sample;
    tx_x_d       = (state_d == ST_ACQ_X) && tx_win;
    tx_y_d       = (state_d == ST_ACQ_Y) && tx_win;
    meas_valid_d = (state_d == ST_DONE);

    // Publish both axes together as DONE is entered.
    if (state_d == ST_DONE) begin
      speed_x_d = shadow_x_d;
      speed_y_d = shadow_y_d;
      err_d     = errp_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clr_cnt_q    <= '0;
      win_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      got_q        <= 1'b0;
      shadow_x_q   <= '0;
      shadow_y_q   <= '0;
      errp_q       <= '0;
      dp_rx1_q     <= '0;
      dp_rx2_q     <= '0;
      dp_endata_q  <= 1'b0;
      dp_reset_q   <= 1'b0;
      tx_x_q       <= 1'b0;
      tx_y_q       <= 1'b0;
      speed_x_q    <= '0;
      speed_y_q    <= '0;
      meas_valid_q <= 1'b0;
      err_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      clr_cnt_q    <= clr_cnt_d;
      win_cnt_q    <= win_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      got_q        <= got_d;
      shadow_x_q   <= shadow_x_d;
      shadow_y_q   <= shadow_y_d;
      errp_q       <= errp_d;
      dp_rx1_q     <= dp_rx1_d;
      dp_rx2_q     <= dp_rx2_d;
      dp_endata_q  <= dp_endata_d;
      dp_reset_q   <= dp_reset_d;
      tx_x_q       <= tx_x_d;
      tx_y_q       <= tx_y_d;
      speed_x_q    <= speed_x_d;
      speed_y_q    <= speed_y_d;
      meas_valid_q <= meas_valid_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  assign dp_rx1     = dp_rx1_q;
  assign dp_rx2     = dp_rx2_q;
  assign dp_endata  = dp_endata_q;
  assign dp_reset   = dp_reset_q;
  assign tx_x       = tx_x_q;
  assign tx_y       = tx_y_q;
  assign speed_x    = speed_x_q;
  assign speed_y    = speed_y_q;
  assign meas_valid = meas_valid_q;
  assign err        = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_wind_meas_sched.sv
// Directed and randomized checks of the wind measurement scheduler against a stub datapath.
module tb_wind_meas_sched;

  localparam int unsigned SAMPLE_DIV = 4;
  localparam int unsigned WINDOW     = 8;
  localparam int unsigned BURST_LEN  = 2;
  localparam int unsigned TIMEOUT    = 16;
  localparam int unsigned CLR_CYC    = 2;

  logic        clock;
  logic        reset;
  logic        start, continuous, abort;
  logic [11:0] rx1, rx2, rx3, rx4;
  logic [11:0] dp_rx1, dp_rx2;
  logic        dp_endata, dp_reset;
  logic [15:0] dp_speed;
  logic        dp_valid;
  logic        tx_x, tx_y;
  logic [15:0] speed_x, speed_y;
  logic        meas_valid;
  logic [1:0]  err;
  logic        busy;

  wind_meas_sched #(
    .SAMPLE_DIV(SAMPLE_DIV),
    .WINDOW    (WINDOW),
    .BURST_LEN (BURST_LEN),
    .TIMEOUT   (TIMEOUT),
    .CLR_CYC   (CLR_CYC)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .continuous(continuous),
    .abort     (abort),
    .rx1       (rx1),
    .rx2       (rx2),
    .rx3       (rx3),
    .rx4       (rx4),
    .dp_rx1    (dp_rx1),
    .dp_rx2    (dp_rx2),
    .dp_endata (dp_endata),
    .dp_reset  (dp_reset),
    .dp_speed  (dp_speed),
    .dp_valid  (dp_valid),
    .tx_x      (tx_x),
    .tx_y      (tx_y),
    .speed_x   (speed_x),
    .speed_y   (speed_y),
    .meas_valid(meas_valid),
    .err       (err),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- output monitor (sole writer of the records below) ----------------
  int          cyc = 0;
  logic [23:0] pair_q[$];
  int          pair_t[$];
  int          txx_runs[$];
  int          txy_runs[$];
  int          rst_runs[$];
  int          txx_len = 0, txy_len = 0, rst_len = 0;
  int          overlap = 0, en_idle = 0, mv_cnt = 0, mv_t = 0, last_en_t = 0;
  logic [15:0] mv_sx = '0, mv_sy = '0;
  logic [1:0]  mv_err = '0;

  always @(negedge clock) begin
    cyc++;
    if (dp_endata) begin
      pair_q.push_back({dp_rx1, dp_rx2});
      pair_t.push_back(cyc);
      last_en_t = cyc;
      if (!busy) en_idle++;
    end
    if (tx_x && tx_y) overlap++;
    if (tx_x) txx_len++;
    else if (txx_len > 0) begin txx_runs.push_back(txx_len); txx_len = 0; end
    if (tx_y) txy_len++;
    else if (txy_len > 0) begin txy_runs.push_back(txy_len); txy_len = 0; end
    if (dp_reset) rst_len++;
    else if (rst_len > 0) begin rst_runs.push_back(rst_len); rst_len = 0; end
    if (meas_valid) begin
      mv_cnt++;
      mv_t   = cyc;
      mv_sx  = speed_x;
      mv_sy  = speed_y;
      mv_err = err;
    end
  end

  // ---------------- stub datapath ----------------
  logic [15:0] val_x, val_y;
  bit          resp_x, resp_y;
  int          dly_x, dly_y;

  initial begin : stub
    int en_cnt;
    int wait_left;
    bit ax;
    en_cnt = 0; wait_left = -1; ax = 1'b0;
    dp_valid = 1'b0; dp_speed = '0;
    forever begin
      @(negedge clock);
      dp_valid = 1'b0;
      if (tx_x) ax = 1'b0;
      if (tx_y) ax = 1'b1;
      if (dp_reset || !busy) begin
        en_cnt = 0; wait_left = -1;
      end else if (dp_endata) begin
        en_cnt++;
        if (en_cnt == int'(WINDOW)) wait_left = ax ? dly_y : dly_x;
      end else if (wait_left == 0) begin
        if (ax ? resp_y : resp_x) begin
          dp_valid = 1'b1;
          dp_speed = ax ? val_y : val_x;
        end
        wait_left = -1;
      end else if (wait_left > 0) begin
        wait_left--;
      end
    end
  end

  // ---------------- reference expectations ----------------
  logic [15:0] last_sx = '0, last_sy = '0;
  logic [1:0]  last_err = '0;

  task automatic tick(input int n = 1);
    repeat (n) begin @(negedge clock); #1; end
  endtask

  task automatic wait_mv(input string tag, input int base, input int target);
    int k = 0;
    while (mv_cnt < base + target && k < 3000) begin tick(); k++; end
    chk({tag, " mv_arrived"}, 32'(mv_cnt >= base + target), 32'd1);
  endtask

  task automatic measure(input string tag);
    int pb, xb, yb, rb, mb, bad, gap, v;
    logic [23:0] ep;
    logic [15:0] esx, esy;
    logic [1:0]  eerr;
    pb = pair_q.size(); xb = txx_runs.size(); yb = txy_runs.size();
    rb = rst_runs.size(); mb = mv_cnt;
    start = 1'b1; tick(); start = 1'b0;
    wait_mv(tag, mb, 1);
    esx  = resp_x ? val_x : 16'h8000;
    esy  = resp_y ? val_y : 16'h8000;
    eerr = {~resp_y, ~resp_x};
    chk({tag, " speed_x"}, 32'(mv_sx), 32'(esx));
    chk({tag, " speed_y"}, 32'(mv_sy), 32'(esy));
    chk({tag, " err"}, 32'(mv_err), 32'(eerr));
    chk({tag, " endata_count"}, 32'(pair_q.size() - pb), 32'(2 * WINDOW));
    bad = 0; gap = 0;
    for (int k = 0; k < int'(2 * WINDOW); k++) begin
      ep = (k < int'(WINDOW)) ? {rx2, rx4} : {rx1, rx3};
      if (pb + k < pair_q.size()) begin
        if (pair_q[pb + k] !== ep) bad++;
        if ((k % int'(WINDOW)) != 0 && pair_t[pb + k] - pair_t[pb + k - 1] != int'(SAMPLE_DIV)) gap++;
      end
    end
    chk({tag, " pair_errors"}, 32'(bad), 32'd0);
    chk({tag, " strobe_gap_errors"}, 32'(gap), 32'd0);
    chk({tag, " tx_x_runs"}, 32'(txx_runs.size() - xb), 32'd1);
    v = (txx_runs.size() > xb) ? txx_runs[xb] : -1;
    chk({tag, " tx_x_len"}, 32'(v), 32'(BURST_LEN * SAMPLE_DIV));
    chk({tag, " tx_y_runs"}, 32'(txy_runs.size() - yb), 32'd1);
    v = (txy_runs.size() > yb) ? txy_runs[yb] : -1;
    chk({tag, " tx_y_len"}, 32'(v), 32'(BURST_LEN * SAMPLE_DIV));
    chk({tag, " dp_reset_runs"}, 32'(rst_runs.size() - rb), 32'd2);
    v = (rst_runs.size() > rb) ? rst_runs[rb] : -1;
    chk({tag, " dp_reset_len_x"}, 32'(v), 32'(CLR_CYC));
    v = (rst_runs.size() > rb + 1) ? rst_runs[rb + 1] : -1;
    chk({tag, " dp_reset_len_y"}, 32'(v), 32'(CLR_CYC));
    chk({tag, " y_latency"}, 32'(mv_t - last_en_t),
        32'(resp_y ? dly_y + 2 : int'(TIMEOUT) + 1));
    tick(3);
    chk({tag, " busy_after"}, 32'(busy), 32'd0);
    chk({tag, " mv_once"}, 32'(mv_cnt - mb), 32'd1);
    last_sx = esx; last_sy = esy; last_err = eerr;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " dp_rx"}, 32'({dp_rx1, dp_rx2}), 32'd0);
    chk({tag, " strobes"}, 32'({dp_endata, dp_reset, tx_x, tx_y, meas_valid, busy}), 32'd0);
    chk({tag, " speeds"}, 32'({speed_x, speed_y}), 32'd0);
    chk({tag, " err"}, 32'(err), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int mb, pb, k;
    reset = 1'b0; start = 1'b0; continuous = 1'b0; abort = 1'b0;
    rx1 = '0; rx2 = '0; rx3 = '0; rx4 = '0;
    val_x = '0; val_y = '0; resp_x = 1'b1; resp_y = 1'b1; dly_x = 0; dly_y = 0;
    tick(3);
    chk_all_zero("reset");
    reset = 1'b1;
    tick(20);
    chk("idle_no_start busy", 32'(busy), 32'd0);
    chk("idle_no_start mv", 32'(mv_cnt), 32'd0);

    // Normal run with the reference pattern.
    rx2 = 12'h100; rx4 = 12'h200; rx1 = 12'h300; rx3 = 12'h400;
    val_x = 16'd25; val_y = 16'hFFF9; dly_x = 3; dly_y = 5;
    measure("normal");

    // Y axis never answers.
    resp_y = 1'b0; val_x = 16'd1234; dly_x = 0;
    measure("timeout_y");
    resp_y = 1'b1;

    // Randomized measurements, one with an X timeout.
    for (int i = 0; i < 4; i++) begin
      rx1 = 12'($urandom); rx2 = 12'($urandom); rx3 = 12'($urandom); rx4 = 12'($urandom);
      val_x = 16'($urandom); val_y = 16'($urandom);
      resp_x = (i != 2); resp_y = 1'($urandom_range(0, 1));
      dly_x = $urandom_range(0, 12); dly_y = $urandom_range(0, 12);
      measure($sformatf("rand%0d", i));
    end
    resp_x = 1'b1; resp_y = 1'b1;

    // Abort during the Y acquisition.
    val_x = 16'h7777; val_y = 16'h6666;
    mb = mv_cnt;
    start = 1'b1; tick(); start = 1'b0;
    k = 0;
    while (!tx_y && k < 500) begin tick(); k++; end
    chk("abort reached_acq_y", 32'(tx_y), 32'd1);
    tick(3);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort tx_y", 32'(tx_y), 32'd0);
    chk("abort endata", 32'(dp_endata), 32'd0);
    tick(100);
    chk("abort no_mv", 32'(mv_cnt - mb), 32'd0);
    chk("abort speed_x", 32'(speed_x), 32'(last_sx));
    chk("abort speed_y", 32'(speed_y), 32'(last_sy));
    chk("abort err", 32'(err), 32'(last_err));

    // Continuous mode with an ignored start while busy.
    val_x = 16'd300; val_y = 16'd400; dly_x = 1; dly_y = 2;
    mb = mv_cnt; pb = pair_q.size();
    continuous = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    wait_mv("cont1", mb, 1);
    tick();
    chk("cont back_to_back dp_reset", 32'(dp_reset), 32'd1);
    chk("cont back_to_back busy", 32'(busy), 32'd1);
    tick(10);
    start = 1'b1; tick(); start = 1'b0;
    continuous = 1'b0;
    wait_mv("cont2", mb, 2);
    chk("cont speed_x", 32'(mv_sx), 32'd300);
    chk("cont speed_y", 32'(mv_sy), 32'd400);
    tick(200);
    chk("cont mv_count", 32'(mv_cnt - mb), 32'd2);
    chk("cont endata_count", 32'(pair_q.size() - pb), 32'(4 * WINDOW));
    chk("cont idle", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of the X acquisition.
    start = 1'b1; tick(); start = 1'b0;
    k = 0;
    while (!tx_x && k < 500) begin tick(); k++; end
    chk("areset reached_acq_x", 32'(tx_x), 32'd1);
    tick(2);
    #2 reset = 1'b0;
    #1 chk_all_zero("areset");
    #10 reset = 1'b1;
    mb = mv_cnt;
    tick(60);
    chk("areset stays_idle", 32'(busy), 32'd0);
    chk("areset no_mv", 32'(mv_cnt - mb), 32'd0);

    chk("tx_overlap", 32'(overlap), 32'd0);
    chk("endata_while_idle", 32'(en_idle), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wind_meas_sched.md
Name: wind_meas_sched

Overview:
- Measurement scheduler for the ultrasonic wind datapath (the `wind` block).
- One datapath instance is shared between the X axis (rx2 upwind, rx4 downwind) and the Y axis (rx1 upwind, rx3 downwind).
- Per measurement it does the following:
  - generates the sample strobe;
  - fires the axis transmitter burst;
  - clears the datapath and routes the correct receiver pair into it for a fixed window;
  - captures the resulting speed.
- Publishes speed_x / speed_y together with a completion pulse.

Parameters:
- SAMPLE_DIV, 100: clock cycles per sample strobe (100 MHz -> 1 MS/s). Must be ≥ 4.
- WINDOW, 2000: sample strobes per axis acquisition window.
- BURST_LEN, 8: sample strobes of transmitter drive at the start of the window.
- TIMEOUT, 4096: clock cycles to wait for dp_valid after the window ends.
- CLR_CYC, 2: cycles dp_reset is held high before each axis.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request for one X+Y measurement
- continuous  in  1  when high, restart automatically after DONE
- abort  in  1  synchronous abort, returns to IDLE
- rx1, rx2, rx3, rx4  in  12 each  raw receiver samples (signed)
- dp_rx1  out  12  upwind sample to datapath
- dp_rx2  out  12  downwind sample to datapath
- dp_endata  out  1  sample-valid strobe to datapath
- dp_reset  out  1  synchronous active-high clear to datapath
- dp_speed  in  16  signed speed from datapath
- dp_valid  in  1  datapath output valid
- tx_x, tx_y  out  1 each  transmitter burst enables
- speed_x, speed_y  out  16  signed captured results
- meas_valid  out  1  one-cycle pulse when both results are updated
- err  out  2  {y_timeout, x_timeout} for the last measurement
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (reset=0) is asynchronous.
  - All outputs go to 0, the state goes to IDLE and the divider goes to 0.
  - speed_x and speed_y reset to 0.
- Divider: counts 0..SAMPLE_DIV-1 and free-runs even in IDLE. Internal strobe stb=1 when count==SAMPLE_DIV-1.
- States: IDLE, CLR_X, ACQ_X, WAIT_X, CLR_Y, ACQ_Y, WAIT_Y, DONE.
- IDLE -> CLR_X on start=1. start is ignored when busy=1.
- CLR_x: dp_reset=1 for CLR_CYC cycles, then go to ACQ_x at the next stb. The got flag is cleared on entry.
- ACQ_x: on each stb, register the axis pair into dp_rx1/dp_rx2.
  - X axis: dp_rx1<=rx2, dp_rx2<=rx4. Y axis: dp_rx1<=rx1, dp_rx2<=rx3.
  - dp_endata=1 exactly one cycle later, for one cycle, so data is stable for the full strobe cycle.
  - tx_x (or tx_y) is high from ACQ entry until BURST_LEN strobes have been counted. Only the active axis transmitter is ever high.
  - After WINDOW strobes go to WAIT_x. dp_endata is 0 in every non-ACQ state. dp_rx1/dp_rx2 hold their last value.
- Capture: in ACQ_x or WAIT_x, any dp_valid=1 loads dp_speed into the axis shadow register and sets got. The last valid wins.
- WAIT_x:
  - If got=1 on entry, leave after 1 cycle.
  - Otherwise wait for dp_valid. On arrival, capture it and go to the next state.
  - If TIMEOUT cycles pass with no dp_valid: set the err bit and load the shadow with 16'sh8000 (sentinel).
  - WAIT_X exits to CLR_Y; WAIT_Y exits to DONE.
- DONE, one cycle:
  - speed_x and speed_y are updated from the shadows simultaneously; err is updated; meas_valid=1.
  - Next state is CLR_X if continuous=1, else IDLE.
- dp_valid outside ACQ/WAIT is ignored.
- abort=1 in any state:
  - go to IDLE next cycle; tx_* and dp_endata go to 0 immediately (registered next edge);
  - speed_x, speed_y and err are not updated and meas_valid is not pulsed.
  - abort has priority over start in the same cycle.
- The window counter saturates at WINDOW. WINDOW=1 and BURST_LEN≥WINDOW are legal; tx stays high for the whole window.
- Minimum latency from start to meas_valid is 2·(CLR_CYC + WINDOW·SAMPLE_DIV) + O(SAMPLE_DIV) cycles.

Decomposition:
- Package wind_pkg holds:
  - state enum encoding;
  - SENTINEL=16'sh8000;
  - the AXIS_X/AXIS_Y select constants;
  - the widths SAMPLE_W=12 and SPEED_W=16.
- One natural sub-module, wind_strobe_gen: the divider producing stb.
  - Parameter: SAMPLE_DIV. Ports: clock, reset.
  - Reusable by the testbench-facing sample source.

Test Plan:
All scenarios use SAMPLE_DIV=4, WINDOW=8, BURST_LEN=2, TIMEOUT=16, CLR_CYC=2.
- Normal run:
  - Stimulus: start pulse, rx2=0x100, rx4=0x200, rx1=0x300, rx3=0x400. Stub datapath asserts dp_valid with dp_speed=16'sd25 after the X window and 16'sd-7 after the Y window.
  - Required: exactly 8 dp_endata pulses per axis, pair (0x100,0x200) then (0x300,0x400); meas_valid once; speed_x=25, speed_y=-7, err=0.
- Burst/window timing:
  - Required: tx_x high for exactly 2 strobes at the start of ACQ_X; tx_y likewise in ACQ_Y; never both high; dp_reset high for 2 cycles before each ACQ.
- Timeout on Y:
  - Stimulus: no dp_valid during the Y axis.
  - Required: meas_valid after 16 WAIT_Y cycles; speed_y=16'sh8000, err=2'b10; speed_x is captured normally.
- Abort mid-ACQ_Y:
  - Stimulus: abort pulse during ACQ_Y.
  - Required: IDLE next cycle, busy=0, tx_y=0, no meas_valid; speed_x and speed_y keep their previous values.
- Continuous, with start while busy:
  - Stimulus: continuous=1 after one start.
  - Required: back-to-back measurements with CLR_X immediately after DONE. An extra start pulse while busy has no effect (the measurement count is unchanged).
- Async reset:
  - Stimulus: reset=0 mid-ACQ_X, off a clock edge.
  - Required: all outputs 0 immediately; after release, the state is IDLE until the next start.
